// File: rtl/prng_pkg.sv
// prng_pkg: shared types and constants for the shared PRNG arbiter.
// FSM states, LFSR tap mask and the nonzero fallback seed.
package prng_pkg;

  typedef enum logic {
    S_IDLE,
    S_RESP
  } fsm_e;

  // Taps at bits 15,13,12,10 give a maximal-period 16-bit sequence.
  localparam logic [15:0] LFSR16_TAP_MASK = 16'hB400;

  localparam logic [15:0] LFSR_NONZERO_DEFAULT = 16'h0001;

  function automatic logic [15:0] lfsr16_next(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & LFSR16_TAP_MASK)};
  endfunction

endpackage

// File: rtl/lfsr16_step.sv
// lfsr16_step: 16-bit Fibonacci LFSR register with load and step.
// A zero load is replaced by the nonzero default so it never locks up.
module lfsr16_step
  import prng_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step_en,
  input  logic        load_en,
  input  logic [15:0] load_data,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Load wins over step; a zero seed falls back to the default.
  always_comb begin
    state_d = state_q;
    if (load_en) begin
      if (load_data == 16'h0000) begin
        state_d = LFSR_NONZERO_DEFAULT;
      end else begin
        state_d = load_data;
      end
    end else if (step_en) begin
      state_d = lfsr16_next(state_q);
    end
  end

  // State register, returns to SEED on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/prng_share_arbiter.sv
// prng_share_arbiter: one LFSR shared by N_REQ requesters.
// Round-robin grants, one response in flight, reseed and draw counter.
module prng_share_arbiter
  import prng_pkg::*;
#(
  parameter int          N_REQ = 4,
  parameter int          WIDTH = 16,
  parameter logic [15:0] SEED  = 16'h0001,
  localparam int         IDW   = $clog2(N_REQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [WIDTH-1:0] seed_data,
  output logic [31:0]      draw_count
);

  fsm_e             fsm_q;
  fsm_e             fsm_d;
  logic [IDW-1:0]   last_q;
  logic [IDW-1:0]   last_d;
  logic             rsp_valid_q;
  logic             rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q;
  logic [IDW-1:0]   rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q;
  logic [WIDTH-1:0] rsp_data_d;
  logic [31:0]      cnt_q;
  logic [31:0]      cnt_d;

  logic             grant_any;
  logic [IDW-1:0]   grant_idx;
  logic             step_en;
  logic             load_en;
  logic [WIDTH-1:0] lfsr_state;

  lfsr16_step #(
    .SEED (SEED)
  ) u_lfsr (
    .clock     (clock),
    .reset     (reset),
    .step_en   (step_en),
    .load_en   (load_en),
    .load_data (seed_data),
    .state     (lfsr_state)
  );

  function automatic logic [IDW-1:0] wrap_idx(
    input int v
  );
    return IDW'(v % N_REQ);
  endfunction

  // Round-robin pick: scan upward from the slot after the last grant.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!grant_any &&
          req_valid[wrap_idx(int'(last_q) + i)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_idx(int'(last_q) + i);
      end
    end
  end

  // Next-state and handshake outputs; reseed beats a draw.
  always_comb begin
    fsm_d       = fsm_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    cnt_d       = cnt_q;
    req_ready   = '0;
    seed_ready  = 1'b0;
    step_en     = 1'b0;
    load_en     = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        if (seed_valid) begin
          seed_ready = 1'b1;
          load_en    = 1'b1;
        end else if (grant_any) begin
          req_ready[grant_idx] = 1'b1;
          step_en     = 1'b1;
          rsp_data_d  = lfsr_state;
          rsp_id_d    = grant_idx;
          rsp_valid_d = 1'b1;
          last_d      = grant_idx;
          cnt_d       = cnt_q + 32'd1;
          fsm_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          fsm_d       = S_IDLE;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
    if (reset) begin
      req_ready  = '0;
      seed_ready = 1'b0;
    end
  end

  // Control, response and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q       <= S_IDLE;
      last_q      <= IDW'(N_REQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      fsm_q       <= fsm_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign draw_count = cnt_q;

endmodule

// File: tb/tb_prng_share_arbiter.sv
// tb_prng_share_arbiter: directed tests plus a cycle-by-cycle model.
// The model walks a precomputed LFSR sequence table by position.
module tb_prng_share_arbiter;

  localparam int N = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        seed_valid = 1'b0;
  logic        seed_ready;
  logic [15:0] seed_data = '0;
  logic [31:0] draw_count;

  prng_share_arbiter #(
    .N_REQ (4),
    .WIDTH (16),
    .SEED  (16'h0001)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .seed_data  (seed_data),
    .draw_count (draw_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  logic [15:0] seq [65535];
  int          pos [65536];
  bit          seen [65536];
  bit          tbl_ok = 1'b0;

  function automatic logic [15:0] nxt(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  bit          m_val = 1'b0;
  bit          m_pend;
  int          m_id;
  logic [15:0] m_data;
  int          m_last;
  int          m_idx;
  logic [31:0] m_cnt;

  always @(negedge clock) begin
    logic [3:0] er;
    logic       es;
    int         g;
    int         c;
    er = '0;
    es = 1'b0;
    g  = -1;
    if (tbl_ok) begin
      if (reset) begin
        chk("m_rst_req_ready", 32'(req_ready), 0);
        chk("m_rst_seed_ready", 32'(seed_ready), 0);
        m_val  = 1'b1;
        m_pend = 1'b0;
        m_id   = 0;
        m_data = '0;
        m_last = N - 1;
        m_idx  = 0;
        m_cnt  = '0;
      end else if (m_val) begin
        chk("m_rsp_valid", 32'(rsp_valid), 32'(m_pend));
        chk("m_draw_count", draw_count, m_cnt);
        if (m_pend) begin
          chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
          chk("m_rsp_data", 32'(rsp_data), 32'(m_data));
        end
        if (!m_pend) begin
          if (seed_valid) begin
            es = 1'b1;
          end else begin
            for (int i = 1; i <= N; i++) begin
              c = (m_last + i) % N;
              if (g < 0 && req_valid[c]) g = c;
            end
            if (g >= 0) er[g] = 1'b1;
          end
        end
        chk("m_req_ready", 32'(req_ready), 32'(er));
        chk("m_seed_ready", 32'(seed_ready), 32'(es));
        if (!m_pend) begin
          if (es) begin
            m_idx = (seed_data == 16'h0000) ? pos[1]
                                            : pos[seed_data];
          end else if (g >= 0) begin
            m_pend = 1'b1;
            m_id   = g;
            m_data = seq[m_idx];
            m_idx  = (m_idx + 1) % 65535;
            m_last = g;
            m_cnt  = m_cnt + 1;
          end
        end else if (rsp_ready) begin
          m_pend = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req_valid  = '0;
    seed_valid = 1'b0;
    rsp_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input logic [3:0] mask,
                            input int eid,
                            output bit ok);
    int n;
    req_valid = mask;
    n = 0;
    @(negedge clock);
    while (req_ready == 4'b0 && n < 20) begin
      n++;
      @(negedge clock);
    end
    ok = (req_ready != 4'b0);
    if (!ok) chk("grant_timeout", 0, 1);
    else chk("grant_onehot", 32'(req_ready), 32'(1 << eid));
    tick();
    req_valid = '0;
  endtask

  task automatic draw(input logic [3:0] mask,
                      input int eid,
                      input logic [15:0] edata);
    bit ok;
    rsp_ready = 1'b0;
    wait_grant(mask, eid, ok);
    if (ok) begin
      chk("draw_rsp_valid", 32'(rsp_valid), 1);
      chk("draw_rsp_id", 32'(rsp_id), 32'(eid));
      chk("draw_rsp_data", 32'(rsp_data), 32'(edata));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] s;
    bit          uniq;
    logic [15:0] d_hold;
    logic [1:0]  id_hold;
    logic [31:0] c_hold;
    bit          ok;
    int          k;
    int          prev;
    bit          pend_chk;
    logic [15:0] exp_d [5];
    int          exp_g [5];

    s = 16'h0001;
    uniq = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      if (s == 16'h0000 || seen[s]) uniq = 1'b0;
      seen[s] = 1'b1;
      seq[i] = s;
      pos[s] = i;
      s = nxt(s);
    end
    chk("period_unique_nonzero", 32'(uniq), 1);
    chk("period_draw65536", 32'(s), 32'h0001);
    chk("seq_pin_11", 32'(seq[11]), 32'h0801);
    chk("seq_pin_after_8000",
        32'(seq[(pos[16'h8000] + 1) % 65535]), 32'h0001);
    tbl_ok = 1'b1;

    do_reset();
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_draw_count", draw_count, 0);

    draw(4'b0001, 0, 16'h0001);
    draw(4'b0001, 0, 16'h0002);
    draw(4'b0001, 0, 16'h0004);
    chk("t1_draw_count", draw_count, 3);

    do_reset();
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    k = 0;
    prev = 0;
    pend_chk = 1'b0;
    for (int c = 0; c < 40 && (k < 5 || pend_chk); c++) begin
      @(negedge clock);
      if (pend_chk) begin
        chk("t2_rsp_data", 32'(rsp_data), 32'(exp_d[k-1]));
        pend_chk = 1'b0;
      end
      if (req_ready != 4'b0 && k < 5) begin
        chk("t2_grant", 32'(req_ready), 32'(1 << exp_g[k]));
        if (k > 0) chk("t2_gap", 32'(c - prev), 2);
        prev = c;
        pend_chk = 1'b1;
        k++;
      end
    end
    if (k < 5) chk("t2_timeout", 32'(k), 5);
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();

    seed_data  = 16'h8000;
    seed_valid = 1'b1;
    req_valid  = 4'b0010;
    @(negedge clock);
    chk("t3_seed_ready", 32'(seed_ready), 1);
    chk("t3_req_ready", 32'(req_ready), 0);
    tick();
    seed_valid = 1'b0;
    draw(4'b0010, 1, 16'h8000);
    draw(4'b0010, 1, 16'h0001);
    seed_data  = 16'h0000;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    draw(4'b0010, 1, 16'h0001);

    rsp_ready = 1'b0;
    wait_grant(4'b0100, 2, ok);
    req_valid  = 4'b1111;
    seed_valid = 1'b1;
    seed_data  = 16'h1234;
    c_hold  = draw_count;
    d_hold  = rsp_data;
    id_hold = rsp_id;
    chk("t4_data", 32'(d_hold), 32'h0002);
    chk("t4_id", 32'(id_hold), 2);
    repeat (5) begin
      @(negedge clock);
      chk("t4_rsp_valid", 32'(rsp_valid), 1);
      chk("t4_hold_data", 32'(rsp_data), 32'(d_hold));
      chk("t4_hold_id", 32'(rsp_id), 32'(id_hold));
      chk("t4_req_ready", 32'(req_ready), 0);
      chk("t4_seed_ready", 32'(seed_ready), 0);
      chk("t4_count", draw_count, c_hold);
    end
    tick();
    seed_valid = 1'b0;
    req_valid  = '0;
    rsp_ready  = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    chk("t4_count_after", draw_count, c_hold);

    wait_grant(4'b0001, 0, ok);
    chk("t5_rsp_valid_pre", 32'(rsp_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    chk("t5_count", draw_count, 0);
    draw(4'b0100, 2, 16'h0001);

    do_reset();
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    repeat (6000) tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    chk("t6_count", draw_count, 3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
